// File: rtl/keypad_scanner.sv
// Scans a 4x3 telephone keypad one column at a time, synchronizes and
// debounces the row returns, and emits one single-cycle strobe per keystroke.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows_n,
    output logic [2:0] col_n,
    output logic [9:0] teclas,
    output logic       enter,
    output logic       star,
    output logic       key_held
);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN         = 2'd0,
        S_DEBOUNCE     = 2'd1,
        S_EMIT         = 2'd2,
        S_WAIT_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [2:0]       col_n_q, col_n_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       teclas_q, teclas_d;
    logic             enter_q, enter_d;
    logic             star_q, star_d;
    logic             key_held_q, key_held_d;

    logic [3:0] rs;
    logic [3:0] low;
    logic       one_low;
    logic [1:0] low_row;
    logic [1:0] col_next;
    logic [3:0] digit;

    assign rs      = sync2_q;
    assign low     = ~rs;
    assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);

    // Row index of the single low return (only meaningful when one_low)
    always_comb begin
        low_row = 2'd0;
        case (low)
            4'b0010: low_row = 2'd1;
            4'b0100: low_row = 2'd2;
            4'b1000: low_row = 2'd3;
            default: low_row = 2'd0;
        endcase
    end

    assign col_next = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
    assign digit    = 4'(row_q) * 4'd3 + 4'(col_idx_q) + 4'd1;

    // Synchronizer, scan/debounce FSM and strobe generation
    always_comb begin
        sync1_d    = rows_n;
        sync2_d    = sync1_q;
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        row_d      = row_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        teclas_d   = 10'd0;
        enter_d    = 1'b0;
        star_d     = 1'b0;
        key_held_d = key_held_q;

        case (state_q)
            S_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (one_low) begin
                        row_d   = low_row;
                        pat_d   = rs;
                        state_d = S_DEBOUNCE;
                    end else begin
                        col_idx_d = col_next;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DEBOUNCE: begin
                if (rs != pat_q) begin
                    cnt_d     = '0;
                    col_idx_d = col_next;
                    state_d   = S_SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EMIT: begin
                if (row_q == 2'd3) begin
                    case (col_idx_q)
                        2'd0:    star_d      = 1'b1;
                        2'd1:    teclas_d[0] = 1'b1;
                        default: enter_d     = 1'b1;
                    endcase
                end else begin
                    teclas_d = 10'(10'd1 << digit);
                end
                key_held_d = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT_RELEASE;
            end
            default: begin
                if (rs != 4'b1111) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                    col_idx_d  = col_next;
                    state_d    = S_SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        col_n_d = ~(3'(3'b001 << col_idx_d));
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_SCAN;
            sync1_q    <= 4'b1111;
            sync2_q    <= 4'b1111;
            col_idx_q  <= 2'd0;
            col_n_q    <= 3'b110;
            row_q      <= 2'd0;
            pat_q      <= 4'b1111;
            cnt_q      <= '0;
            teclas_q   <= 10'd0;
            enter_q    <= 1'b0;
            star_q     <= 1'b0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            col_idx_q  <= col_idx_d;
            col_n_q    <= col_n_d;
            row_q      <= row_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            teclas_q   <= teclas_d;
            enter_q    <= enter_d;
            star_q     <= star_d;
            key_held_q <= key_held_d;
        end
    end

    assign col_n    = col_n_q;
    assign teclas   = teclas_q;
    assign enter    = enter_q;
    assign star     = star_q;
    assign key_held = key_held_q;

endmodule

// File: doc/keypad_scanner.md
Name:
keypad_scanner

Overview:
- Matrix-keypad front end that scans a 4x3 telephone keypad, synchronizes and debounces the row returns, and delivers keystrokes on the keypad interface: one-hot `teclas[9:0]` and `enter`.
- Sits between the physical keypad pins and the password/keypad checker.
- Each press produces exactly one single-cycle pulse, whether the key is held long or bounces.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven during scanning; minimum 2.
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required for press and for release; minimum 2.
- CNT_W, 20, width of the dwell and debounce counters; must hold max(SCAN_DIV, DEBOUNCE_CYCLES).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset; synchronous, active-low.
- rows_n  input  4  keypad row returns; active-low with pull-ups; asynchronous to clk.
- col_n  output  3  column drive; active-low; exactly one bit low at all times.
- teclas  output  10  one-hot digit strobe; bit i = digit i; high for one cycle per press.
- enter  output  1  one-cycle strobe for '#'.
- star  output  1  one-cycle strobe for '*'.
- key_held  output  1  high from the emit cycle until release debounce completes.

Behaviour:
- Key map (row, col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- Input synchronization: rows_n passes through a 2-flop synchronizer (reset 4'b1111); all decisions use the synchronized value rs.
- Reset (rst=0 at posedge):
  - state=SCAN, column index 0, col_n=3'b110.
  - teclas=0, enter=0, star=0, key_held=0; all counters 0.
- SCAN:
  - Dwell counter counts 0..SCAN_DIV-1 on the current column. At dwell end, sample rs.
  - Exactly one bit low: latch column and row, go to DEBOUNCE, keep that column driven.
  - Otherwise (none, or ≥2 rows low): advance column 0→1→2→0, col_n follows on the same edge, dwell restarts.
- DEBOUNCE:
  - Each cycle rs equals the latched pattern: count++.
  - Any mismatch: clear count, advance column, return to SCAN.
  - count reaches DEBOUNCE_CYCLES: go to EMIT.
- EMIT (one cycle):
  - Registered outputs pulse on the next clock edge: digit → teclas bit set, '#' → enter, '*' → star.
  - key_held set. Go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Column stays driven.
  - rs==4'b1111 for DEBOUNCE_CYCLES consecutive cycles: key_held cleared, advance column, go to SCAN.
  - Any low bit clears the count.
  - A second key pressed while held is never reported.
- Strobe exclusivity:
  - teclas, enter and star are mutually exclusive and never high two consecutive cycles.
  - teclas is always 0 or one-hot.
- Latency: strobe appears DEBOUNCE_CYCLES+1 cycles after the dwell-end capture edge.
- Multi-key: ≥2 rows low on one column is ignored. Keys in different columns: the first column scanned wins.
- Reset mid-operation:
  - Returns to the reset state immediately.
  - A key still held is re-detected and emits exactly one new strobe after debounce.
- Counters never wrap; they saturate at their terminal value or are cleared on state change.

Test Plan:
Run with SCAN_DIV=4, DEBOUNCE_CYCLES=8. The bench models the keypad: rows_n[r]=0 iff key (r,c) is pressed and col_n[c]=0.
1. Reset: rst=0 for 3 cycles with no keys → col_n=3'b110, teclas=0, enter=0, star=0, key_held=0. After release, col_n steps 110→101→011→110 every 4 cycles.
2. Press '5' (r1,c1) for 60 cycles, then release → exactly one cycle with teclas=10'b0000100000. key_held high from that cycle until 8 cycles of all-high rs after release. Scanning then resumes.
3. '#' bounces (toggle every 3 cycles for 24 cycles), then held 40 cycles → exactly one enter pulse, which occurs only after 8 stable cycles. teclas=0 and star=0 throughout.
4. Press '*' → one star pulse, teclas=0, enter=0. Press '0' next → teclas=10'b0000000001 once.
5. Press '1' and '4' together (both col0) for 100 cycles → no strobe, key_held=0, col_n keeps cycling.
6. Hold '0'; assert rst=0 for 2 cycles during WAIT_RELEASE → outputs clear and col_n=3'b110. After reset release, exactly one further teclas[0] pulse occurs while '0' is still held.
